// File: rtl/mdr_mem_port.sv
// mdr_mem_port: memory address register (MAR) and memory data register (MDR)
// with a single-word request/acknowledge memory handshake.
// The MDR feeds the datapath bus MDR source. MAR, MDR and the write data are
// loaded from the bus. A Moore FSM sequences reads and writes. Each transfer
// allows a variable number of wait states and times out after WAIT_MAX
// request cycles that see no acknowledge.
module mdr_mem_port #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 9,
  parameter int WAIT_MAX = 15
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [DATA_W-1:0] BusMuxOut,
  input  logic              MARin,
  input  logic              MDRin,
  input  logic              Read,
  input  logic              Write,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] MDR_q,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // WAIT_MAX is at most 255, so an 8-bit counter never wraps before timeout.
  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_MAX);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t              state_r;
  state_t              state_n_s;
  logic [ADDR_W-1:0]   mar_r;
  logic [ADDR_W-1:0]   mar_n_s;
  logic [DATA_W-1:0]   mdr_r;
  logic [DATA_W-1:0]   mdr_n_s;
  logic [CNT_W-1:0]    cnt_r;
  logic [CNT_W-1:0]    cnt_n_s;
  logic [CNT_W-1:0]    cnt_inc_s;
  logic                err_r;
  logic                err_n_s;
  logic                timeout_s;
  logic                req_n_s;
  logic                we_n_s;
  logic                busy_n_s;
  logic                done_n_s;

  // A state that drives a memory request.
  function automatic logic is_xfer(input state_t s);
    return (s == ST_RD) || (s == ST_WR);
  endfunction

  // A state that is not IDLE. Command strobes are ignored in these states.
  function automatic logic is_busy(input state_t s);
    return (s != ST_IDLE);
  endfunction

  // The counter value after this request cycle, and whether that value is the timeout.
  assign cnt_inc_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
  assign timeout_s = (cnt_inc_s == WAIT_LAST);

  // Next-state, register-load and sticky-error decisions for the FSM.
  always_comb begin
    state_n_s = state_r;
    mar_n_s   = mar_r;
    mdr_n_s   = mdr_r;
    cnt_n_s   = cnt_r;
    err_n_s   = err_r;
    case (state_r)
      ST_IDLE: begin
        // Loads land on the same edge as the strobe, so a transfer started
        // in this cycle sees the new MAR and MDR values.
        if (MARin) begin
          mar_n_s = BusMuxOut[ADDR_W-1:0];
        end else begin
          mar_n_s = mar_r;
        end
        if (MDRin) begin
          mdr_n_s = BusMuxOut;
        end else begin
          mdr_n_s = mdr_r;
        end
        if (Read && Write) begin
          err_n_s   = 1'b1;
          state_n_s = ST_IDLE;
        end else if (Read) begin
          state_n_s = ST_RD;
          cnt_n_s   = {CNT_W{1'b0}};
          err_n_s   = 1'b0;
        end else if (Write) begin
          state_n_s = ST_WR;
          cnt_n_s   = {CNT_W{1'b0}};
          err_n_s   = 1'b0;
        end else begin
          state_n_s = ST_IDLE;
        end
      end
      ST_RD: begin
        if (mem_ack) begin
          mdr_n_s   = mem_rdata;
          state_n_s = ST_DONE;
          cnt_n_s   = {CNT_W{1'b0}};
        end else if (timeout_s) begin
          // Give up. MDR keeps its old value and no done pulse follows.
          err_n_s   = 1'b1;
          state_n_s = ST_IDLE;
          cnt_n_s   = {CNT_W{1'b0}};
        end else begin
          cnt_n_s   = cnt_inc_s;
        end
      end
      ST_WR: begin
        if (mem_ack) begin
          state_n_s = ST_DONE;
          cnt_n_s   = {CNT_W{1'b0}};
        end else if (timeout_s) begin
          err_n_s   = 1'b1;
          state_n_s = ST_IDLE;
          cnt_n_s   = {CNT_W{1'b0}};
        end else begin
          cnt_n_s   = cnt_inc_s;
        end
      end
      ST_DONE: begin
        state_n_s = ST_IDLE;
      end
      default: begin
        // An unreachable encoding recovers to a quiet IDLE.
        state_n_s = ST_IDLE;
        cnt_n_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Moore output values are decoded from the next state. This lets them be registered with no input-to-output path.
  always_comb begin
    req_n_s  = is_xfer(state_n_s);
    we_n_s   = (state_n_s == ST_WR);
    busy_n_s = is_busy(state_n_s);
    done_n_s = (state_n_s == ST_DONE);
  end

  // State, datapath registers and registered outputs. A synchronous clear has priority over everything else.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_r <= ST_IDLE;
      mar_r   <= {ADDR_W{1'b0}};
      mdr_r   <= {DATA_W{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      err_r   <= 1'b0;
      mem_req <= 1'b0;
      mem_we  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_r <= state_n_s;
      mar_r   <= mar_n_s;
      mdr_r   <= mdr_n_s;
      cnt_r   <= cnt_n_s;
      err_r   <= err_n_s;
      mem_req <= req_n_s;
      mem_we  <= we_n_s;
      busy    <= busy_n_s;
      done    <= done_n_s;
    end
  end

  // Register views. MAR drives the address, and MDR drives both the write data and the bus source.
  assign mem_addr  = mar_r;
  assign mem_wdata = mdr_r;
  assign MDR_q     = mdr_r;
  assign err       = err_r;

endmodule

// File: doc/mdr_mem_port.md
Name: mdr_mem_port

Overview:
Memory data register (MDR) and memory address register (MAR) with a request/acknowledge memory handshake. Sits directly upstream of the datapath bus multiplexer: its MDR_q output is the MDR source the bus selects when MDRout is asserted. It also consumes BusMuxOut to load MAR, to load MDR, and to supply write data. A Moore FSM sequences single-word reads and writes with variable wait states and a timeout.

Parameters:
DATA_W, 32, data width; matches BusMuxOut.
ADDR_W, 9, MAR width; taken from BusMuxOut[ADDR_W-1:0].
WAIT_MAX, 15, cycles without mem_ack in RD/WR before timeout; legal range 1..255.

Ports:
clk  input  1  single system clock; all state changes on the rising edge.
clr  input  1  synchronous, active-high reset.
BusMuxOut  input  DATA_W  datapath bus value.
MARin  input  1  load MAR from bus; honoured only in IDLE.
MDRin  input  1  load MDR from bus; honoured only in IDLE.
Read  input  1  start memory read at MAR; honoured only in IDLE.
Write  input  1  start memory write of MDR to MAR; honoured only in IDLE.
mem_rdata  input  DATA_W  memory read data; valid when mem_ack=1.
mem_ack  input  1  memory completion strobe.
mem_req  output  1  memory request.
mem_we  output  1  1 means write, 0 means read; meaningful only while mem_req=1.
mem_addr  output  ADDR_W  current MAR.
mem_wdata  output  DATA_W  current MDR.
MDR_q  output  DATA_W  MDR contents; feeds the bus MDR source.
busy  output  1  high in any state other than IDLE.
done  output  1  one-cycle pulse when a transfer completes.
err  output  1  sticky timeout or command-conflict flag.

Behaviour:
- Reset (clr=1 at a clock edge) takes priority over all other inputs, including mid-transaction:
  - state becomes IDLE; MAR=0, MDR=0, wait counter=0.
  - mem_req, mem_we, busy, done and err all become 0.
- States: IDLE, RD, WR, DONE. All outputs are decoded from registers (Moore); there is no combinational path from any input to any output.
- IDLE, in the same edge:
  - MARin=1 loads MAR from BusMuxOut[ADDR_W-1:0].
  - MDRin=1 loads MDR from BusMuxOut.
  - Read=1 and Write=0: go to RD, clear counter, clear err.
  - Write=1 and Read=0: go to WR, clear counter, clear err.
    - If MARin or MDRin is asserted in the same cycle, the transfer uses the newly loaded value.
  - Read=1 and Write=1 together: set err=1, stay in IDLE. MAR/MDR loads in that cycle still occur.
- RD: mem_req=1, mem_we=0.
  - mem_ack=1: MDR <= mem_rdata, go to DONE.
  - Otherwise counter increments. When the counter reaches WAIT_MAX with no ack: set err=1, go to IDLE, MDR unchanged, no done pulse.
- WR: mem_req=1, mem_we=1, mem_wdata=MDR.
  - mem_ack=1: go to DONE.
  - Timeout is handled as in RD.
- DONE: done=1 for exactly one cycle, then IDLE. mem_req=0.
- Latency:
  - Strobe at edge N gives mem_req=1 in cycle N+1.
  - Ack sampled at edge M updates MDR at M; done is high in cycle M+1.
  - Zero-wait read (ack in the first request cycle): strobe to done = 2 cycles.
- Timing: a timeout occurs when WAIT_MAX consecutive request cycles pass with no ack. mem_req is dropped at the timeout edge.
- mem_ack outside RD/WR is ignored. A late ack arriving after timeout does not modify MDR.
- MARin, MDRin, Read and Write are ignored while busy=1. MAR and MDR stay stable for the whole transaction.
- err stays at 1 until clr or the next accepted Read/Write.
- MDR_q is always the MDR register. mem_addr is always the MAR register. No width truncation is applied to data.

Test Plan:
1. Reset mid-RD (mem_req=1), clr=1 for one edge -> next cycle: state IDLE, mem_req=0, MDR_q=0, busy=0, err=0.
2. BusMuxOut=0x0000_0012 with MARin=1 and Read=1 in the same cycle; memory acks after 3 wait cycles with mem_rdata=0xDEAD_BEEF -> mem_addr=0x012, mem_req high for 4 cycles, MDR_q=0xDEAD_BEEF, done pulses for 1 cycle, busy falls with done.
3. MDRin=1 with BusMuxOut=0xCAFE_0001, then MARin with 0x1FF, then Write; ack in the first request cycle -> mem_we=1, mem_wdata=0xCAFE_0001, mem_addr=0x1FF; done high 2 cycles after the Write strobe.
4. Read with no ack and WAIT_MAX=15 -> mem_req high exactly 15 cycles, then err=1, busy=0, no done pulse, MDR_q unchanged. A later ack leaves MDR_q unchanged. The next Read clears err.
5. Read=Write=1 in IDLE with MDRin=1 and BusMuxOut=0x5 -> err=1, no mem_req, MDR_q=0x5.
6. During a busy RD, pulse MARin=1 (BusMuxOut=0x0AA), MDRin=1 and Write=1 -> all ignored: mem_addr and the in-flight read are unaffected, and no write follows the read.
